// File: rtl/pattern_count_top.sv
// Pattern-search engine: scans a 32-byte message held in a local data memory
// for a 5-bit pattern, counting byte-local hits, bytes with any hit, and all
// windows of the bit stream, then writes the three counts back to memory.

module pattern_count_mem (
  input  logic       clk,
  input  logic [7:0] raddr_a,
  input  logic [7:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata
);

  logic [7:0] core [256];

  assign rdata_a = core[raddr_a];
  assign rdata_b = core[raddr_b];

  // Single synchronous write port; contents are never cleared so preloads survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      core[waddr] <= wdata;
    end
  end

endmodule

module pattern_count_top #(
  parameter int MSG_BYTES = 32,
  parameter int PAT_ADDR  = 32,
  parameter int RES_ADDR  = 33
) (
  input  logic clk,
  input  logic reset,
  output logic done
);

  localparam logic [7:0] LAST_IDX = 8'(MSG_BYTES - 1);
  localparam logic [7:0] PAT_A    = 8'(PAT_ADDR);
  localparam logic [7:0] RES_A    = 8'(RES_ADDR);

  typedef enum logic [2:0] {
    PAT,
    SCAN,
    W0,
    W1,
    W2,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  index;
  logic [4:0]  pattern;
  logic [7:0]  ctb;
  logic [7:0]  cto;
  logic [7:0]  cts;

  logic [7:0]  rd_addr_a;
  logic [7:0]  rd_addr_b;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [7:0]  mem_wdata;

  logic        last_byte;
  logic [7:0]  cur;
  logic [7:0]  nxt;
  logic [2:0]  local_hits;
  logic [3:0]  cross_hits;

  pattern_count_mem dm1 (
    .clk     (clk),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rd_data_a),
    .rdata_b (rd_data_b),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata)
  );

  assign last_byte = (index == LAST_IDX);
  assign rd_addr_a = (state == PAT) ? PAT_A : index;
  assign rd_addr_b = index + 8'd1;
  assign cur       = rd_data_a;
  assign nxt       = last_byte ? 8'h00 : rd_data_b;

  // Count pattern hits in the current byte and in the 16-bit cur/nxt window;
  // on the final byte only the four windows that lie inside it are counted
  always_comb begin
    logic [15:0] w;
    local_hits = 3'd0;
    cross_hits = 4'd0;
    w = {cur, nxt};
    for (int k = 0; k < 4; k++) begin
      if (cur[k +: 5] == pattern) begin
        local_hits = local_hits + 3'd1;
      end
    end
    for (int o = 0; o < 8; o++) begin
      if ((o < 4 || !last_byte) && (w[15 - o -: 5] == pattern)) begin
        cross_hits = cross_hits + 4'd1;
      end
    end
  end

  // Result write-back: one memory write per write state, blocked while in reset
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = RES_A;
    mem_wdata = ctb;
    case (state)
      W0: begin
        mem_we    = reset;
        mem_waddr = RES_A;
        mem_wdata = ctb;
      end
      W1: begin
        mem_we    = reset;
        mem_waddr = RES_A + 8'd1;
        mem_wdata = cto;
      end
      W2: begin
        mem_we    = reset;
        mem_waddr = RES_A + 8'd2;
        mem_wdata = cts;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Control FSM: fetch pattern, scan one byte per edge, write three results, then hold done
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= PAT;
      index   <= 8'd0;
      pattern <= 5'd0;
      ctb     <= 8'd0;
      cto     <= 8'd0;
      cts     <= 8'd0;
      done    <= 1'b0;
    end else begin
      case (state)
        PAT: begin
          pattern <= rd_data_a[7:3];
          index   <= 8'd0;
          state   <= SCAN;
        end
        SCAN: begin
          ctb <= ctb + {5'd0, local_hits};
          cto <= cto + {7'd0, (local_hits != 3'd0)};
          cts <= cts + {4'd0, cross_hits};
          if (last_byte) begin
            state <= W0;
          end else begin
            index <= index + 8'd1;
          end
        end
        W0: begin
          state <= W1;
        end
        W1: begin
          state <= W2;
        end
        W2: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= PAT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_count_top.sv
// Bench for pattern_count_top: preloads message/pattern into dm1.core, runs the
// engine and compares latency and written counts against a bit-stream model.

module tb_pattern_count_top;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] msg [32];
  logic [4:0] pat;
  logic [7:0] pat_byte;
  int exp_ctb;
  int exp_cto;
  int exp_cts;

  pattern_count_top dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference: count matches over the 256-bit MSB-first stream and per byte
  function automatic void compute_model();
    logic [255:0] bits;
    int b;
    int hits;
    for (int i = 0; i < 32; i++) begin
      bits[255 - 8 * i -: 8] = msg[i];
    end
    exp_ctb = 0;
    exp_cto = 0;
    exp_cts = 0;
    for (int i = 0; i < 32; i++) begin
      b = int'(msg[i]);
      hits = 0;
      for (int s = 0; s < 4; s++) begin
        if (((b >> s) & 31) == int'(pat)) hits++;
      end
      exp_ctb += hits;
      if (hits > 0) exp_cto++;
    end
    for (int p = 0; p < 252; p++) begin
      if (bits[255 - p -: 5] == pat) exp_cts++;
    end
  endfunction

  // Hold reset, preload memory, release and count edges until done (-1 on timeout)
  task automatic start_and_wait(output int edges);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    pat_byte = {pat, 3'b101};
    for (int i = 0; i < 32; i++) dut.dm1.core[i] = msg[i];
    dut.dm1.core[32] = pat_byte;
    for (int i = 33; i < 37; i++) dut.dm1.core[i] = 8'hEE;
    reset = 1'b1;
    edges = 0;
    forever begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
      if (edges >= 200) begin
        edges = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    pat = 5'b10101;
    pat_byte = {pat, 3'b101};
    reset = 1'b0;
    dut.dm1.core[32] = pat_byte;
    dut.dm1.core[33] = 8'hEE;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_done got=%b want=0", done);
    end
    tests_run++;
    if (dut.dm1.core[33] !== 8'hEE) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_write got=%h want=ee", dut.dm1.core[33]);
    end
  endtask

  task automatic test_directed();
    int edges;
    int ec [6][3];
    ec[0] = '{128, 32, 252};
    ec[1] = '{64, 32, 126};
    ec[2] = '{128, 32, 252};
    ec[3] = '{0, 0, 0};
    ec[4] = '{0, 0, 1};
    ec[5] = '{1, 1, 1};
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 32; i++) msg[i] = 8'h00;
      case (c)
        0: pat = 5'b00000;
        1: begin pat = 5'b10101; for (int i = 0; i < 32; i++) msg[i] = 8'h55; end
        2: begin pat = 5'b11111; for (int i = 0; i < 32; i++) msg[i] = 8'hFF; end
        3: pat = 5'b11111;
        4: begin pat = 5'b11111; msg[0] = 8'h07; msg[1] = 8'hC0; end
        default: begin pat = 5'b10101; msg[31] = 8'hA8; end
      endcase
      start_and_wait(edges);
      tests_run++;
      if (edges != 36) begin
        tests_failed++;
        $display("[TB] FAIL dir%0d_latency got=%0d want=36", c, edges);
      end
      tests_run++;
      if (int'(dut.dm1.core[33]) != ec[c][0]) begin
        tests_failed++;
        $display("[TB] FAIL dir%0d_ctb got=%0d want=%0d", c, dut.dm1.core[33], ec[c][0]);
      end
      tests_run++;
      if (int'(dut.dm1.core[34]) != ec[c][1]) begin
        tests_failed++;
        $display("[TB] FAIL dir%0d_cto got=%0d want=%0d", c, dut.dm1.core[34], ec[c][1]);
      end
      tests_run++;
      if (int'(dut.dm1.core[35]) != ec[c][2]) begin
        tests_failed++;
        $display("[TB] FAIL dir%0d_cts got=%0d want=%0d", c, dut.dm1.core[35], ec[c][2]);
      end
    end
  endtask

  task automatic test_random();
    int edges;
    int pos;
    logic [15:0] pair;
    for (int n = 0; n < 8; n++) begin
      pat = 5'($urandom_range(0, 31));
      for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        pos = $urandom_range(0, 30);
        pair = {msg[pos], msg[pos + 1]};
        pair[15 - (k * 3) -: 5] = pat;
        msg[pos] = pair[15:8];
        msg[pos + 1] = pair[7:0];
      end
      compute_model();
      start_and_wait(edges);
      tests_run++;
      if (edges != 36) begin
        tests_failed++;
        $display("[TB] FAIL rnd%0d_latency got=%0d want=36", n, edges);
      end
      tests_run++;
      if (int'(dut.dm1.core[33]) != exp_ctb || int'(dut.dm1.core[34]) != exp_cto ||
          int'(dut.dm1.core[35]) != exp_cts) begin
        tests_failed++;
        $display("[TB] FAIL rnd%0d_results got=%0d/%0d/%0d want=%0d/%0d/%0d", n,
                 dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35], exp_ctb, exp_cto, exp_cts);
      end
    end
  endtask

  task automatic test_done_hold();
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    repeat (12) @(posedge clk);
    #1;
    r0 = 8'(exp_ctb);
    r1 = 8'(exp_cto);
    r2 = 8'(exp_cts);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hold_done got=%b want=1", done);
    end
    tests_run++;
    if (dut.dm1.core[33] !== r0 || dut.dm1.core[34] !== r1 || dut.dm1.core[35] !== r2 ||
        dut.dm1.core[36] !== 8'hEE) begin
      tests_failed++;
      $display("[TB] FAIL hold_results got=%h/%h/%h/%h want=%h/%h/%h/ee",
               dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35], dut.dm1.core[36], r0, r1, r2);
    end
  endtask

  task automatic test_midrun_reset();
    int edges;
    int bad;
    pat = 5'b01101;
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    msg[7] = 8'b0110_1011;
    compute_model();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    pat_byte = {pat, 3'b101};
    for (int i = 0; i < 32; i++) dut.dm1.core[i] = msg[i];
    dut.dm1.core[32] = pat_byte;
    for (int i = 33; i < 36; i++) dut.dm1.core[i] = 8'hEE;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_done_low got=%b want=0", done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    edges = 0;
    forever begin
      @(posedge clk);
      #1;
      edges++;
      if (done || edges >= 200) break;
    end
    if (!done) edges = -1;
    tests_run++;
    if (edges != 36) begin
      tests_failed++;
      $display("[TB] FAIL midrun_latency got=%0d want=36", edges);
    end
    tests_run++;
    if (int'(dut.dm1.core[33]) != exp_ctb || int'(dut.dm1.core[34]) != exp_cto ||
        int'(dut.dm1.core[35]) != exp_cts) begin
      tests_failed++;
      $display("[TB] FAIL midrun_results got=%0d/%0d/%0d want=%0d/%0d/%0d",
               dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35], exp_ctb, exp_cto, exp_cts);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut.dm1.core[i] !== msg[i]) bad++;
    if (dut.dm1.core[32] !== pat_byte) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_inputs_intact got=%0d changed bytes want=0", bad);
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_done_hold();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pattern_count_top.md
Name: pattern_count_top

Overview:
- Self-contained pattern-search engine for program 3.
- Holds a 256x8 data memory, instance dm1, array core. The bench preloads a 32-byte message at core[0..31] and a 5-bit pattern at core[32][7:3].
- After reset release it counts pattern occurrences three ways, writes the counts to core[33..35], then raises done.
- It is the top of the design; the testbench drives only clk and reset and watches done.

Parameters:
- MSG_BYTES, 32, number of message bytes scanned (addresses 0..MSG_BYTES-1).
- PAT_ADDR, 32, address of the pattern byte.
- RES_ADDR, 33, first result address; results go to RES_ADDR, RES_ADDR+1, RES_ADDR+2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset. 0 = held in reset; 1 = run.
- done  output  1  registered; high when all three results are written.

Behaviour:
- Memory dm1.core: 256x8 with two asynchronous read ports and one synchronous write port.
  - Contents are not cleared by reset, so bench preloads survive.
  - Only the write states modify memory.
- Reset (reset==0 at a clock edge):
  - state <= PAT, ctb=cto=cts=0, index=0, pattern reg=0, done=0.
  - Reset mid-operation aborts and restarts from PAT on release. Results already written may remain until overwritten.
- PAT (first edge with reset==1): pattern <= core[32][7:3]; index <= 0; go SCAN.
- SCAN, one byte per edge, index 0..31:
  - cur = core[index]; nxt = core[index+1] for index<31, else 8'h00.
  - Stream order: core[0] bit7 is the first bit of the 256-bit string.
  - Byte-local windows: cur[4:0], cur[5:1], cur[6:2], cur[7:3].
    - ctb += number of these windows equal to pattern (0..4).
    - cto += 1 if any of them match.
  - Crossing windows: let w = {cur,nxt} (16 bits). Window o = w[15-o:11-o], o=0..7.
    - cts += number of matching windows.
    - For index 31 only o=0..3 are counted, giving 252 windows in total.
  - Exit after index 31.
- Write states, one edge each:
  - W0: core[33] <= ctb.
  - W1: core[34] <= cto.
  - W2: core[35] <= cts; state <= DONE.
- DONE: done=1, held until reset goes low. No further memory writes and no auto-restart.
- Latency, counting edge 1 as the first edge with reset high:
  - PAT at edge 1; SCAN at edges 2..33; writes at edges 34..36.
  - done goes high after edge 36.
- Widths and ranges:
  - All counters are 8-bit unsigned.
  - Maxima: ctb 128, cto 32, cts 252. No overflow is possible.
- A pattern value of 0 is legal and is matched like any other value.

Test Plan:
- pat=00000, all 32 bytes 0x00 -> core[33]=128, core[34]=32, core[35]=252; done high 36 cycles after release.
- pat=10101, all bytes 0x55 -> core[33]=64, core[34]=32, core[35]=126.
- pat=11111, all bytes 0xFF -> 128, 32, 252. Same pattern with all bytes 0x00 -> 0, 0, 0.
- Byte crossing: pat=11111, core[0]=0x07, core[1]=0xC0, rest 0x00 -> core[33]=0, core[34]=0, core[35]=1.
- Pattern 10101 placed only in byte 31 bits [7:3] (core[31]=0xA8), rest 0 -> ctb=1, cto=1, cts=1. This confirms index-31 crossing windows are masked correctly.
- Reset mid-run: pull reset low at cycle 10, release.
  - done drops while in reset and rises exactly 36 edges after the second release.
  - Results are identical to an uninterrupted run.
  - core[0..32] are unchanged.
